// File: rtl/cache_pkg.sv
// cache_pkg: shared geometry and sweep FSM encoding for the N-way tag store.
package cache_pkg;
  localparam int TAG_WIDTH   = 25;
  localparam int CACHE_LINES = 128;
  localparam int INDEX_WIDTH = 7;
  localparam int WAYS        = 4;
  localparam int WAY_W       = $clog2(WAYS);
  typedef enum logic {SWEEP, READY} state_t;
endpackage

// File: rtl/tag_way_ram.sv
// tag_way_ram: read-first synchronous tag RAM for one way, no reset so it infers block RAM.
module tag_way_ram #(
  parameter int DW = 25,
  parameter int AW = 7
) (
  input  logic          clk,
  input  logic [AW-1:0] index,
  input  logic [AW-1:0] wr_index,
  input  logic [DW-1:0] data_in,
  input  logic          we,
  output logic [DW-1:0] data_out
);
  logic [DW-1:0] r_mem [2**AW];
  always_ff @(posedge clk) begin
    if (we) r_mem[wr_index] <= data_in;
    data_out <= r_mem[index];
  end
endmodule

// File: rtl/tag_array_nway.sv
// tag_array_nway: N-way set-associative tag store with registered lookup, victim selection
// and a self-timed valid/dirty invalidation sweep on reset and flush.
module tag_array_nway
  import cache_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush_req,
  output logic                   init_done,
  input  logic                   lookup_valid,
  input  logic [INDEX_WIDTH-1:0] lookup_index,
  input  logic [TAG_WIDTH-1:0]   lookup_tag,
  output logic                   result_valid,
  output logic                   hit,
  output logic [WAY_W-1:0]       hit_way,
  output logic [WAY_W-1:0]       victim_way,
  output logic                   victim_valid,
  output logic                   victim_dirty,
  output logic [TAG_WIDTH-1:0]   victim_tag,
  input  logic                   wr_en,
  input  logic [INDEX_WIDTH-1:0] wr_index,
  input  logic [WAY_W-1:0]       wr_way,
  input  logic [TAG_WIDTH-1:0]   wr_tag,
  input  logic                   wr_valid,
  input  logic                   wr_dirty,
  input  logic                   wr_fill
);
  state_t                 r_state, w_state_nxt;
  logic [INDEX_WIDTH-1:0] r_cnt;
  logic [WAYS-1:0]        r_valid [CACHE_LINES];
  logic [WAYS-1:0]        r_dirty [CACHE_LINES];
  logic [WAY_W-1:0]       r_rr [CACHE_LINES];
  logic                   r_req;
  logic [WAYS-1:0]        r_set_valid, r_set_dirty;
  logic [WAY_W-1:0]       r_set_rr;
  logic [TAG_WIDTH-1:0]   r_lk_tag;
  logic                   r_hit, r_res, r_vic_valid, r_vic_dirty;
  logic [WAY_W-1:0]       r_hit_way, r_vic_way;
  logic [TAG_WIDTH-1:0]   r_vic_tag;
  logic [TAG_WIDTH-1:0]   w_rd_tag [WAYS];
  logic [WAYS-1:0]        w_match;
  logic [WAY_W-1:0]       w_hit_way, w_vic;
  logic                   w_ready, w_lk, w_wr;
  assign w_ready      = r_state == READY;
  assign w_lk         = w_ready & lookup_valid;
  assign w_wr         = w_ready & wr_en;
  assign init_done    = w_ready;
  assign result_valid = r_res;
  assign hit          = r_hit;
  assign hit_way      = r_hit_way;
  assign victim_way   = r_vic_way;
  assign victim_valid = r_vic_valid;
  assign victim_dirty = r_vic_dirty;
  assign victim_tag   = r_vic_tag;
  for (genvar i = 0; i < WAYS; i++) begin : g_way
    tag_way_ram #(.DW(TAG_WIDTH), .AW(INDEX_WIDTH)) u_ram (
      .clk      (clk),
      .index    (lookup_index),
      .wr_index (wr_index),
      .data_in  (wr_tag),
      .we       (w_wr && wr_way == WAY_W'(i)),
      .data_out (w_rd_tag[i])
    );
  end
  always_comb
    w_state_nxt = w_ready ? (flush_req ? SWEEP : READY)
                          : (r_cnt == INDEX_WIDTH'(CACHE_LINES - 1) ? READY : SWEEP);
  // Downward scan so the lowest-numbered matching/invalid way wins.
  always_comb begin
    w_match   = '0;
    w_hit_way = '0;
    w_vic     = r_set_rr;
    for (int k = 0; k < WAYS; k++) w_match[k] = r_set_valid[k] && w_rd_tag[k] == r_lk_tag;
    for (int k = WAYS - 1; k >= 0; k--) begin
      if (w_match[k]) w_hit_way = WAY_W'(k);
      if (!r_set_valid[k]) w_vic = WAY_W'(k);
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= SWEEP;
      r_cnt   <= '0;
      for (int k = 0; k < CACHE_LINES; k++) begin
        r_valid[k] <= '0;
        r_dirty[k] <= '0;
        r_rr[k]    <= '0;
      end
    end else begin
      r_state <= w_state_nxt;
      if (!w_ready) begin
        r_valid[r_cnt] <= '0;
        r_dirty[r_cnt] <= '0;
        r_rr[r_cnt]    <= '0;
        r_cnt          <= r_cnt + 1'b1;
      end else begin
        r_cnt <= '0;
        if (wr_en) begin
          r_valid[wr_index][wr_way] <= wr_valid;
          r_dirty[wr_index][wr_way] <= wr_dirty;
          if (wr_fill) r_rr[wr_index] <= wr_way + 1'b1;
        end
      end
    end
  end
  // Stage 1 snapshots the set's flops alongside the RAM read, giving read-first semantics.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_req       <= 1'b0;
      r_set_valid <= '0;
      r_set_dirty <= '0;
      r_set_rr    <= '0;
      r_lk_tag    <= '0;
    end else begin
      r_req <= w_lk;
      if (w_lk) begin
        r_set_valid <= r_valid[lookup_index];
        r_set_dirty <= r_dirty[lookup_index];
        r_set_rr    <= r_rr[lookup_index];
        r_lk_tag    <= lookup_tag;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_res       <= 1'b0;
      r_hit       <= 1'b0;
      r_hit_way   <= '0;
      r_vic_way   <= '0;
      r_vic_valid <= 1'b0;
      r_vic_dirty <= 1'b0;
      r_vic_tag   <= '0;
    end else begin
      r_res <= r_req;
      if (r_req) begin
        r_hit       <= |w_match;
        r_hit_way   <= w_hit_way;
        r_vic_way   <= w_vic;
        r_vic_valid <= r_set_valid[w_vic];
        r_vic_dirty <= r_set_dirty[w_vic];
        r_vic_tag   <= w_rd_tag[w_vic];
      end
    end
  end
endmodule

// File: tb/tb_tag_array_nway.sv
// tb_tag_array_nway: directed vectors with hand-computed expectations for tag_array_nway.
module tb_tag_array_nway;
  import cache_pkg::*;
  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic                   flush_req = 1'b0;
  logic                   init_done;
  logic                   lookup_valid = 1'b0;
  logic [INDEX_WIDTH-1:0] lookup_index = '0;
  logic [TAG_WIDTH-1:0]   lookup_tag = '0;
  logic                   result_valid, hit, victim_valid, victim_dirty;
  logic [WAY_W-1:0]       hit_way, victim_way;
  logic [TAG_WIDTH-1:0]   victim_tag;
  logic                   wr_en = 1'b0;
  logic [INDEX_WIDTH-1:0] wr_index = '0;
  logic [WAY_W-1:0]       wr_way = '0;
  logic [TAG_WIDTH-1:0]   wr_tag = '0;
  logic                   wr_valid = 1'b0, wr_dirty = 1'b0, wr_fill = 1'b0;
  int n_chk = 0;
  int n_err = 0;
  tag_array_nway dut (
    .clk(clk), .rst_n(rst_n), .flush_req(flush_req), .init_done(init_done),
    .lookup_valid(lookup_valid), .lookup_index(lookup_index), .lookup_tag(lookup_tag),
    .result_valid(result_valid), .hit(hit), .hit_way(hit_way),
    .victim_way(victim_way), .victim_valid(victim_valid), .victim_dirty(victim_dirty),
    .victim_tag(victim_tag), .wr_en(wr_en), .wr_index(wr_index), .wr_way(wr_way),
    .wr_tag(wr_tag), .wr_valid(wr_valid), .wr_dirty(wr_dirty), .wr_fill(wr_fill)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic wr(input logic [INDEX_WIDTH-1:0] idx, input logic [WAY_W-1:0] way,
                    input logic [TAG_WIDTH-1:0] tag, input logic v, input logic d, input logic f);
    wr_en = 1'b1; wr_index = idx; wr_way = way; wr_tag = tag;
    wr_valid = v; wr_dirty = d; wr_fill = f;
    tick();
    wr_en = 1'b0; wr_fill = 1'b0;
  endtask
  task automatic look(input logic [INDEX_WIDTH-1:0] idx, input logic [TAG_WIDTH-1:0] tag);
    lookup_valid = 1'b1; lookup_index = idx; lookup_tag = tag;
    tick();
    lookup_valid = 1'b0;
    tick();
  endtask
  task automatic wait_init(input string tag);
    int n = 0;
    while (!init_done && n < 300) begin
      tick();
      n++;
    end
    chk(tag, 32'(n), 32'd128);
  endtask
  initial begin
    int bad;
    #2;
    chk("rst_init_done", 32'(init_done), 0);
    chk("rst_result_valid", 32'(result_valid), 0);
    chk("rst_hit", 32'(hit), 0);
    chk("rst_victim", 32'({victim_way, victim_valid, victim_dirty}), 0);
    chk("rst_victim_tag", 32'(victim_tag), 0);
    tick();
    rst_n = 1'b1;
    wait_init("sweep_len_reset");
    look(7'd5, 25'h1);
    chk("idle_rv", 32'(result_valid), 1);
    chk("idle_hit", 32'(hit), 0);
    chk("idle_vway", 32'(victim_way), 0);
    chk("idle_vvalid", 32'(victim_valid), 0);
    tick();
    chk("rv_one_cycle", 32'(result_valid), 0);
    wr(7'd5, 2'd2, 25'h0ABCDE, 1'b1, 1'b1, 1'b0);
    look(7'd5, 25'h0ABCDE);
    chk("w5_hit", 32'(hit), 1);
    chk("w5_hit_way", 32'(hit_way), 2);
    look(7'd5, 25'h0ABCDF);
    chk("w5_miss_hit", 32'(hit), 0);
    chk("w5_miss_vway", 32'(victim_way), 0);
    chk("w5_miss_hway", 32'(hit_way), 0);
    for (int w = 0; w < WAYS; w++) wr(7'd9, WAY_W'(w), 25'h100 + 25'(w), 1'b1, 1'b0, 1'b1);
    look(7'd9, 25'h999);
    chk("fill_hit", 32'(hit), 0);
    chk("fill_vway", 32'(victim_way), 0);
    chk("fill_vvalid", 32'(victim_valid), 1);
    chk("fill_vdirty", 32'(victim_dirty), 0);
    chk("fill_vtag", 32'(victim_tag), 32'h100);
    look(7'd9, 25'h102);
    chk("fill_hit2", 32'({hit, hit_way}), 32'b110);
    wr(7'd9, 2'd0, 25'h200, 1'b1, 1'b0, 1'b1);
    look(7'd9, 25'h999);
    chk("rr_vway", 32'(victim_way), 1);
    chk("rr_vtag", 32'(victim_tag), 32'h101);
    lookup_valid = 1'b1; lookup_index = 7'd3; lookup_tag = 25'h7;
    wr_en = 1'b1; wr_index = 7'd3; wr_way = 2'd1; wr_tag = 25'h7;
    wr_valid = 1'b1; wr_dirty = 1'b0;
    tick();
    lookup_valid = 1'b0; wr_en = 1'b0;
    tick();
    chk("rf_rv", 32'(result_valid), 1);
    chk("rf_pre_hit", 32'(hit), 0);
    look(7'd3, 25'h7);
    chk("rf_post_hit", 32'(hit), 1);
    chk("rf_post_way", 32'(hit_way), 1);
    for (int s = 0; s < CACHE_LINES; s++) wr(INDEX_WIDTH'(s), 2'd3, 25'(s), 1'b1, 1'b1, 1'b0);
    look(7'd100, 25'd100);
    chk("pop_hit", 32'({hit, hit_way}), 32'b111);
    chk("pop_vway", 32'(victim_way), 0);
    look(7'd9, 25'd9);
    chk("pop9_hit", 32'({hit, hit_way}), 32'b111);
    flush_req = 1'b1;
    tick();
    flush_req = 1'b0;
    chk("flush_init_low", 32'(init_done), 0);
    lookup_valid = 1'b1; lookup_index = 7'd100; lookup_tag = 25'd100;
    wr_en = 1'b1; wr_index = 7'd127; wr_way = 2'd0; wr_tag = 25'h55;
    wr_valid = 1'b1; wr_dirty = 1'b1;
    bad = 0;
    begin
      int n = 0;
      while (!init_done && n < 300) begin
        tick();
        n++;
        if (result_valid) bad++;
      end
      chk("sweep_len_flush", 32'(n), 32'd128);
    end
    lookup_valid = 1'b0; wr_en = 1'b0;
    chk("sweep_rv_quiet", 32'(bad), 0);
    look(7'd100, 25'd100);
    chk("post_hit100", 32'(hit), 0);
    chk("post_vdirty100", 32'(victim_dirty), 0);
    chk("post_vvalid100", 32'(victim_valid), 0);
    look(7'd127, 25'h55);
    chk("post_wr_ignored", 32'(hit), 0);
    look(7'd9, 25'd9);
    chk("post_hit9", 32'(hit), 0);
    chk("post_v9", 32'({victim_way, victim_valid, victim_dirty}), 0);
    flush_req = 1'b1;
    tick();
    flush_req = 1'b0;
    for (int i = 0; i < 60; i++) tick();
    chk("mid_sweep_low", 32'(init_done), 0);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_init", 32'(init_done), 0);
    chk("mid_rst_rv", 32'(result_valid), 0);
    tick();
    tick();
    rst_n = 1'b1;
    wait_init("sweep_len_rerun");
    look(7'd5, 25'h0ABCDE);
    chk("rerun_rv", 32'(result_valid), 1);
    chk("rerun_hit", 32'(hit), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
